// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_multi
//  Purpose  : Multi-channel mechanical key debouncer. Each active-low key is
//             passed through a 2-flop synchroniser and then through a
//             per-channel stability FSM. The FSM produces a debounced level
//             and one-cycle press/release strobes. An optional long-press
//             detector can be built in.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - synchronous active-low reset
//             key_n        - [KEY_NUM] raw asynchronous keys, 0 = pressed
//             deb_key_n    - [KEY_NUM] debounced level, 0 = pressed
//             key_press    - [KEY_NUM] 1-cycle pulse on debounced 1->0
//             key_release  - [KEY_NUM] 1-cycle pulse on debounced 0->1
//             key_long     - [KEY_NUM] 1-cycle long-press pulse
//  Macro    : KEY_DEBOUNCE_LONG_PRESS_EN - builds the per-channel hold
//             counters. When it is undefined, key_long is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
  parameter int KEY_NUM     = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEB_MS      = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] deb_key_n,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int DEB_CNT  = CLK_FREQ_HZ / 1000 * DEB_MS;
  localparam int LONG_CNT = CLK_FREQ_HZ / 1000 * LONG_MS;
  // The counter only ever has to hold 0..DEB_CNT-1.
  localparam int CNT_W    = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Elaboration-time parameter sanity checks.
  if (DEB_CNT < 2) begin : g_deb_cnt_check
    $error("key_debounce_multi: DEB_CNT must be at least 2");
  end
  if (LONG_CNT < 2) begin : g_long_cnt_check
    $error("key_debounce_multi: LONG_CNT must be at least 2");
  end

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. Flops reset to 1 (= released) so that a key held
  // through reset is seen as a fresh press afterwards.
  // --------------------------------------------------------------------------
  logic [KEY_NUM-1:0] s1_q;
  logic [KEY_NUM-1:0] key_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '1;
      key_s_q <= '1;
    end else begin
      s1_q    <= key_n;
      key_s_q <= s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Independent per-channel debounce FSMs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             key_s;

    assign key_s = key_s_q[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (!key_s) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          // One high sample aborts the whole count.
          if (key_s) begin
            state_d = ST_RELEASED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            deb_d   = 1'b0;
            press_d = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (key_s) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!key_s) begin
            state_d = ST_PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            deb_d   = 1'b1;
            rel_d   = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
          deb_d   = 1'b1;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_RELEASED;
        cnt_q   <= CNT_ZERO;
        deb_q   <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign deb_key_n[g]   = deb_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CNT);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // The hold counter is held at zero while released or waiting for a
    // press, so it always starts from zero when PRESSED is entered. A bounce
    // back from RELEASE_WAIT keeps counting: it is still the same press.
    // Parking at LONG_CNT after the pulse gives one key_long per press.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) begin
        if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
          hold_d = HOLD_SAT;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end else begin
        hold_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign key_long[g] = long_q;
`else
    assign key_long[g] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce_multi
//  Purpose  : Self-checking bench for key_debounce_multi. DEB_CNT=100 and
//             LONG_CNT=500. Expected strobes are queued with their exact
//             cycle when stimulus is applied, and a negedge monitor pops and
//             compares them. It also tracks the expected debounced level.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

  localparam int KEY_NUM = 4;
  localparam int LAT     = 102;   // 2 sync flops + DEB_CNT
  localparam int LONGLAT = 500;   // key_press cycle -> key_long cycle

  logic               clk = 1'b0;
  logic               rst_n;
  logic [KEY_NUM-1:0] key_n;
  logic [KEY_NUM-1:0] deb_key_n;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  key_debounce_multi #(
    .KEY_NUM    (KEY_NUM),
    .CLK_FREQ_HZ(100_000),
    .DEB_MS     (1),
    .LONG_MS    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .deb_key_n  (deb_key_n),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 clk = ~clk;

  // Cycle index = number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 press, 1 release, 2 long
  } ev_t;

  ev_t                sb_q[$];
  int                 vectors     = 0;
  int                 miscompares = 0;
  logic               mon_en      = 1'b0;
  logic [KEY_NUM-1:0] exp_deb     = '1;
  int                 m_idx;
  logic               m_b;

  function automatic string kname(int k);
    if (k == 0) return "press";
    if (k == 1) return "release";
    return "long";
  endfunction

  function automatic void push_ev(int c, int ch, int k);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    sb_q.push_back(e);
  endfunction

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < KEY_NUM; ch++) begin
        for (int k = 0; k < 3; k++) begin
          m_b = (k == 0) ? key_press[ch] : (k == 1) ? key_release[ch] : key_long[ch];
          m_idx = -1;
          foreach (sb_q[i])
            if (sb_q[i].ch == ch && sb_q[i].kind == k && sb_q[i].cyc == cyc) m_idx = i;
          if (m_idx >= 0) begin
            vectors++;
            if (m_b !== 1'b1) begin
              miscompares++;
              $display("FAIL sb_%s ch%0d cyc %0d: got %b, want 1", kname(k), ch, cyc, m_b);
            end
            if (k == 0) exp_deb[ch] = 1'b0;
            else if (k == 1) exp_deb[ch] = 1'b1;
            sb_q.delete(m_idx);
          end else if (m_b !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_%s ch%0d cyc %0d: got %b, want 0", kname(k), ch, cyc, m_b);
          end
        end
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL stale_%s ch%0d: expected at cyc %0d, not seen", kname(sb_q[i].kind),
                   sb_q[i].ch, sb_q[i].cyc);
          sb_q.delete(i);
        end
      end
      vectors++;
      if (deb_key_n !== exp_deb) begin
        miscompares++;
        $display("FAIL deb_level cyc %0d: got %b, want %b", cyc, deb_key_n, exp_deb);
      end
    end
  end

  // Advance n rising edges, then step just past the edge to drive inputs.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_n = 4'b0000;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (deb_key_n !== 4'b1111) begin
        miscompares++;
        $display("FAIL reset_deb: got %b, want 1111", deb_key_n);
      end
      vectors++;
      if ({key_press, key_release, key_long} !== 12'b0) begin
        miscompares++;
        $display("FAIL reset_strobes: got %b, want 0", {key_press, key_release, key_long});
      end
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int ch = 0; ch < KEY_NUM; ch++) push_ev(cyc + LAT, ch, 0);
    tick(150);
    key_n = 4'b1111;
    for (int ch = 0; ch < KEY_NUM; ch++) push_ev(cyc + LAT, ch, 1);
    tick(150);
    vectors++;
    if (deb_key_n !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_release_all: got %b, want 1111", deb_key_n);
    end
  endtask

  task automatic test_clean_press;
    key_n[0] = 1'b0;
    push_ev(cyc + LAT, 0, 0);
    tick(300);
    vectors++;
    if (deb_key_n[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_held: got %b, want 0", deb_key_n[0]);
    end
    key_n[0] = 1'b1;
    push_ev(cyc + LAT, 0, 1);
    tick(150);
  endtask

  task automatic test_bounce;
    for (int t = 0; t < 20; t++) begin
      key_n[1] = t[0];
      tick(20);
    end
    key_n[1] = 1'b0;
    push_ev(cyc + LAT, 1, 0);
    tick(150);
    key_n[1] = 1'b1;
    push_ev(cyc + LAT, 1, 1);
    tick(150);
  endtask

  task automatic test_glitch;
    key_n[2] = 1'b0;
    tick(99);
    key_n[2] = 1'b1;
    tick(150);
    vectors++;
    if (deb_key_n[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_99: got %b, want 1", deb_key_n[2]);
    end
    key_n[2] = 1'b0;
    push_ev(cyc + LAT, 2, 0);
    tick(100);
    key_n[2] = 1'b1;
    push_ev(cyc + LAT, 2, 1);
    tick(250);
  endtask

  task automatic test_concurrent;
    key_n[3] = 1'b0;
    push_ev(cyc + LAT, 3, 0);
    tick(150);
    key_n[0] = 1'b0;
    key_n[3] = 1'b1;
    push_ev(cyc + LAT, 0, 0);
    push_ev(cyc + LAT, 3, 1);
    tick(150);
    vectors++;
    if (deb_key_n !== 4'b1110) begin
      miscompares++;
      $display("FAIL concurrent_level: got %b, want 1110", deb_key_n);
    end
    key_n[0] = 1'b1;
    push_ev(cyc + LAT, 0, 1);
    tick(150);
  endtask

  task automatic test_long_press;
    key_n[0] = 1'b0;
    push_ev(cyc + LAT, 0, 0);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    push_ev(cyc + LAT + LONGLAT, 0, 2);
`endif
    tick(1000);
    key_n[0] = 1'b1;
    push_ev(cyc + LAT, 0, 1);
    tick(150);
    // A 300-cycle hold is well short of the threshold.
    key_n[0] = 1'b0;
    push_ev(cyc + LAT, 0, 0);
    tick(300);
    key_n[0] = 1'b1;
    push_ev(cyc + LAT, 0, 1);
    tick(150);
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_concurrent();
    test_long_press();
    tick(10);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised, multi-channel successor to the single-key debouncer. It synchronises KEY_NUM active-low mechanical key inputs, filters contact bounce with a per-channel stability counter, and outputs debounced levels plus one-cycle press and release strobes. It sits between board push-buttons and control FSMs in the same 50 MHz clock domain. A long-press detector is optional.

## Interface
- KEY_NUM, 4: number of independent key channels (≥1).
- CLK_FREQ_HZ, 50_000_000: clk frequency in Hz.
- DEB_MS, 20: required stable time in ms. DEB_CNT = CLK_FREQ_HZ/1000*DEB_MS cycles (integer, ≥2).
- LONG_MS, 1000: long-press threshold in ms. LONG_CNT = CLK_FREQ_HZ/1000*LONG_MS. Used only with the macro.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- key_n  input  KEY_NUM  raw asynchronous keys, 0 = pressed.
- deb_key_n  output  KEY_NUM  debounced level, 0 = pressed.
- key_press  output  KEY_NUM  1-cycle pulse on debounced 1→0.
- key_release  output  KEY_NUM  1-cycle pulse on debounced 0→1.
- key_long  output  KEY_NUM  1-cycle long-press pulse. Tied 0 without the macro.

## Operation
- Each channel is fully independent. There is no shared state between channels.
- Synchroniser: 2-flop chain per bit, key_n → s1 → key_s.
- Per-channel FSM states:
  - RELEASED: deb=1.
  - PRESS_WAIT: deb=1, counting.
  - PRESSED: deb=0.
  - RELEASE_WAIT: deb=0, counting.
- Transitions:
  - RELEASED→PRESS_WAIT when key_s=0. Counter loads 1.
  - PRESS_WAIT→RELEASED when key_s=1 (bounce). Counter clears.
  - PRESS_WAIT→PRESSED when key_s=0 and cnt==DEB_CNT-1. deb←0, key_press←1, counter clears.
  - PRESSED→RELEASE_WAIT when key_s=1. Counter loads 1.
  - RELEASE_WAIT→PRESSED when key_s=0 (bounce). Counter clears.
  - RELEASE_WAIT→RELEASED when key_s=1 and cnt==DEB_CNT-1. deb←1, key_release←1.
- Counter width is $clog2(DEB_CNT). It never exceeds DEB_CNT-1, so wrap-around cannot occur.
- A single opposite sample during a WAIT state aborts the count. A glitch shorter than DEB_CNT cycles therefore never changes deb_key_n.
- key_press and key_release are never high in the same cycle for one channel.

## Timing
- Reset (rst_n=0 at a clk edge) values:
  - deb_key_n = all 1s.
  - key_press, key_release, key_long = 0.
  - Synchroniser flops = 1.
  - FSMs = RELEASED.
  - All counters = 0.
- Reset mid-count discards progress. After release from reset, a held key needs a full 2+DEB_CNT cycles to register.
- Latency: a clean input edge at cycle 0 → key_s changes at edge 2 → deb_key_n and its strobe change at edge 2+DEB_CNT.
- All outputs are registered. Strobes are exactly one clk wide and coincide with the deb_key_n change.
- Simultaneous events on different channels are handled in the same cycle with no arbitration.

## Configuration
- KEY_DEBOUNCE_LONG_PRESS_EN:
  - Defined: each channel has a hold counter of width $clog2(LONG_CNT+1). It clears on entering PRESSED and increments each cycle in PRESSED or RELEASE_WAIT. When it reaches LONG_CNT-1, key_long pulses for one cycle and the counter saturates. This gives at most one key_long per press; the next press re-arms it. The counter clears on return to RELEASED or on reset.
  - Undefined: no hold counters are instantiated and key_long is constant 0.

## Test plan
Bench parameters: KEY_NUM=4, CLK_FREQ_HZ=100_000, DEB_MS=1 (DEB_CNT=100), LONG_MS=5 (LONG_CNT=500), 20 ns clk, rst_n low for 5 cycles.

- Reset: rst_n=0 with key_n=4'b0000 → deb_key_n=4'b1111 and all strobes 0 throughout reset. After rst_n=1, deb_key_n[0] falls exactly 102 cycles later.
- Clean press on ch0: key_n[0] held 0 for 300 cycles → deb_key_n[0] falls at cycle 102 with key_press[0] high for exactly that cycle. Release → deb_key_n[0] rises 102 cycles after the key_n edge, with one key_release[0] pulse.
- Bounce: on ch1, toggle key_n[1] every 20 cycles for 400 cycles, then hold 0 → no strobe during toggling. One key_press[1] 102 cycles after the final edge.
- Glitch: a 99-cycle low pulse on ch2 → deb_key_n[2] stays 1. A 100-cycle pulse (as seen at key_s) → one press strobe, followed by a release.
- Concurrency: ch0 pressed and ch3 released on the same edge → key_press[0] and key_release[3] assert in the same cycle. Channels 1 and 2 stay unchanged.
- Long press (macro defined):
  - Hold ch0 for 1000 cycles → key_long[0] pulses once, 500 cycles after the key_press[0] cycle.
  - A 300-cycle hold → no key_long.
  - Macro undefined → key_long stays 0.
